// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// State and owner encodings are fixed so debug taps decode the same everywhere.
package mem_arb_pkg;

    localparam int DATA_W         = 16;
    localparam int STARVE_MAX_DEF = 4;
    localparam int BURST_MAX_DEF  = 8;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        IO_BURST = 2'd1,
        YIELD    = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_IO   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_rdret.sv
// Read-return path: remembers which port owns the read issued last cycle
// and steers the synchronous memory data to that port only.
module mem_arb_rdret
    import mem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_rd_gnt_i,
    input  logic              io_rd_gnt_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              io_rvalid_o,
    output logic [DATA_W-1:0] io_rdata_o
);

    owner_t owner_q, owner_d;

    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_rd_gnt_i) begin
            owner_d = OWN_CPU;
        end else if (io_rd_gnt_i) begin
            owner_d = OWN_IO;
        end
    end

    // A read in flight during reset is discarded, never returned.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign cpu_rvalid_o = (owner_q == OWN_CPU);
    assign io_rvalid_o  = (owner_q == OWN_IO);
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
    assign io_rdata_o   = io_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port unified memory (CPU vs IO) with
// starvation guard and bounded IO bursts. Optional MEM_ARB_STATS_EN adds counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int BURST_MAX  = BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic              io_lock,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       io_grant_cnt,
`endif
    output logic [1:0]        dbg_state
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        cpu_gnt = 1'b0;
        io_gnt  = 1'b0;
        unique case (state_q)
            ARB: begin
                if (cpu_req && io_req) begin
                    if (starve_q == STARVE_LIM) begin
                        io_gnt = 1'b1;
                    end else begin
                        cpu_gnt = 1'b1;
                    end
                end else begin
                    cpu_gnt = cpu_req;
                    io_gnt  = io_req;
                end
                if (io_gnt && io_lock) begin
                    state_d = IO_BURST;
                    burst_d = BW'(1);
                end
            end
            IO_BURST: begin
                // A saturated burst hands over without granting IO again.
                if (burst_q == BURST_LIM && cpu_req) begin
                    state_d = YIELD;
                end else begin
                    io_gnt = io_req;
                    if (io_req && burst_q != BURST_LIM) begin
                        burst_d = burst_q + BW'(1);
                    end
                    if (!io_req || !io_lock) begin
                        state_d = ARB;
                        burst_d = '0;
                    end else if (burst_d == BURST_LIM && cpu_req) begin
                        state_d = YIELD;
                    end
                end
            end
            YIELD: begin
                cpu_gnt = cpu_req;
                state_d = ARB;
                burst_d = '0;
            end
            default: begin
                state_d = ARB;
                burst_d = '0;
            end
        endcase
    end

    always_comb begin
        starve_d = '0;
        if (io_req && !io_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            starve_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (io_gnt) begin
            mem_addr  = io_addr;
            mem_we    = io_we;
            mem_wdata = io_wdata;
        end
    end

    mem_arb_rdret u_rdret (
        .clk_i        (clk),
        .reset_i      (reset),
        .cpu_rd_gnt_i (cpu_gnt && !cpu_we),
        .io_rd_gnt_i  (io_gnt && !io_we),
        .mem_rdata_i  (mem_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .io_rvalid_o  (io_rvalid),
        .io_rdata_o   (io_rdata)
    );

    assign dbg_state = state_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_q, io_grant_q;

    // Both counters wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
            io_grant_q <= '0;
        end else begin
            if (cpu_req && io_req) begin
                conflict_q <= conflict_q + 16'd1;
            end
            if (io_gnt) begin
                io_grant_q <= io_grant_q + 16'd1;
            end
        end
    end

    assign conflict_cnt = conflict_q;
    assign io_grant_cnt = io_grant_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps plus randomized traffic against a
// behavioural model of the grant rules. Stats checks need MEM_ARB_STATS_EN.
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int SMAX = 4;
    localparam int BMAX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req, cpu_we, io_req, io_we, io_lock;
    logic [AW-1:0] cpu_addr, io_addr, mem_addr;
    logic [15:0]   cpu_wdata, io_wdata, mem_wdata, mem_rdata, cpu_rdata, io_rdata;
    logic          cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_we;
    logic [1:0]    dbg_state;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt, io_grant_cnt;
`endif

    mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_lock(io_lock), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_STATS_EN
        .conflict_cnt(conflict_cnt), .io_grant_cnt(io_grant_cnt),
`endif
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: how long IO has waited, how many IO grants the
    // current locked run has taken, whether the CPU is owed one turn,
    // and who is owed read data next cycle (0 none, 1 cpu, 2 io).
    int          m_wait, m_run, m_owner;
    bit          m_yield;
    logic [15:0] m_conf, m_iog;

    logic          obs_cg, obs_ig, obs_mwe, obs_crv, obs_irv;
    logic [AW-1:0] obs_ma;
    logic [15:0]   obs_mwd, obs_crd, obs_ird, obs_conf, obs_iog;
    logic [1:0]    obs_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_wait = 0; m_run = 0; m_owner = 0; m_yield = 1'b0;
        m_conf = '0; m_iog = '0;
    endtask

    task automatic set_cpu(input bit rq, input bit we, input logic [AW-1:0] a, input logic [15:0] d);
        cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_io(input bit rq, input bit we, input bit lk, input logic [AW-1:0] a, input logic [15:0] d);
        io_req = rq; io_we = we; io_lock = lk; io_addr = a; io_wdata = d;
    endtask

    // Inputs are already applied (just after a negedge); check, then advance model.
    task automatic cycle();
        bit eg_c, eg_i;
        logic [AW-1:0] e_ma;
        logic          e_we;
        logic [15:0]   e_wd;
        #1;
        eg_c = 1'b0; eg_i = 1'b0;
        if (m_yield) begin
            eg_c = cpu_req;
        end else if (m_run > 0) begin
            if (!(m_run >= BMAX && cpu_req)) eg_i = io_req;
        end else if (cpu_req && io_req) begin
            if (m_wait >= SMAX) eg_i = 1'b1; else eg_c = 1'b1;
        end else begin
            eg_c = cpu_req; eg_i = io_req;
        end
        e_ma = eg_c ? cpu_addr : (eg_i ? io_addr : '0);
        e_we = eg_c ? cpu_we : (eg_i ? io_we : 1'b0);
        e_wd = eg_c ? cpu_wdata : (eg_i ? io_wdata : '0);

        obs_cg = cpu_gnt; obs_ig = io_gnt; obs_ma = mem_addr; obs_mwe = mem_we;
        obs_mwd = mem_wdata; obs_crv = cpu_rvalid; obs_crd = cpu_rdata;
        obs_irv = io_rvalid; obs_ird = io_rdata; obs_st = dbg_state;
        chk("cpu_gnt", cpu_gnt, eg_c);
        chk("io_gnt", io_gnt, eg_i);
        chk("one_gnt", cpu_gnt & io_gnt, 0);
        chk("mem_addr", mem_addr, e_ma);
        chk("mem_we", mem_we, e_we);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("cpu_rvalid", cpu_rvalid, m_owner == 1);
        chk("cpu_rdata", cpu_rdata, (m_owner == 1) ? mem_rdata : 16'h0);
        chk("io_rvalid", io_rvalid, m_owner == 2);
        chk("io_rdata", io_rdata, (m_owner == 2) ? mem_rdata : 16'h0);
`ifdef MEM_ARB_STATS_EN
        obs_conf = conflict_cnt; obs_iog = io_grant_cnt;
        chk("conflict_cnt", conflict_cnt, m_conf);
        chk("io_grant_cnt", io_grant_cnt, m_iog);
`endif
        if (reset) begin
            model_clear();
        end else begin
            m_owner = (eg_c && !cpu_we) ? 1 : ((eg_i && !io_we) ? 2 : 0);
            m_wait  = (io_req && !eg_i) ? ((m_wait < SMAX) ? m_wait + 1 : SMAX) : 0;
            if (m_yield) begin
                m_yield = 1'b0; m_run = 0;
            end else if (m_run > 0) begin
                if (m_run >= BMAX && cpu_req) begin
                    m_yield = 1'b1;
                end else begin
                    if (eg_i && m_run < BMAX) m_run++;
                    if (!io_req || !io_lock) m_run = 0;
                    else if (m_run == BMAX && cpu_req) m_yield = 1'b1;
                end
            end else if (eg_i && io_lock) begin
                m_run = 1;
            end
            if (cpu_req && io_req) m_conf++;
            if (eg_i) m_iog++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        set_cpu(0, 0, '0, '0); set_io(0, 0, 0, '0, '0);
        mem_rdata = 16'($urandom);
    endtask

    logic [9:0]  both_io_pat  = 10'b10_0001_0000;
    logic [9:0]  both_cpu_pat = 10'b01_1110_1111;
    logic [12:0] bst_io_pat   = 13'b1_0000_1111_1111;
    logic [12:0] bst_cpu_pat  = 13'b0_1111_0000_0000;

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();

        // Reset state: idle inputs, every output low, FSM in ARB
        cycle();
        chk("rst_state", obs_st, 2'd0);
        chk("rst_rvalid", obs_crv | obs_irv, 0);

        // CPU-only read
        set_cpu(1, 0, 16'h0010, 16'h0); mem_rdata = 16'h0;
        cycle();
        chk("cpu_rd_gnt", obs_cg, 1);
        chk("cpu_rd_addr", obs_ma, 16'h0010);
        idle(); mem_rdata = 16'hBEEF;
        cycle();
        chk("cpu_rd_valid", obs_crv, 1);
        chk("cpu_rd_data", obs_crd, 16'hBEEF);
        chk("cpu_rd_io_quiet", {obs_irv, obs_ird}, 0);

        // Both requesting continuously without lock
        for (int i = 0; i < 10; i++) begin
            set_cpu(1, 0, 16'($urandom), 16'($urandom));
            set_io(1, 0, 0, 16'($urandom), 16'($urandom));
            mem_rdata = 16'($urandom);
            cycle();
            chk("both_io_pat", obs_ig, both_io_pat[i]);
            chk("both_cpu_pat", obs_cg, both_cpu_pat[i]);
        end

        // IO write
        idle(); cycle();
        set_io(1, 1, 0, 16'h0100, 16'h1234);
        cycle();
        chk("wr_we", obs_mwe, 1);
        chk("wr_addr", obs_ma, 16'h0100);
        chk("wr_data", obs_mwd, 16'h1234);
        idle();
        cycle();
        chk("wr_no_rvalid", obs_irv, 0);

        // Locked IO burst with the CPU waiting
        for (int i = 0; i < 13; i++) begin
            set_cpu(i != 0, 0, 16'($urandom), 16'($urandom));
            set_io(1, 0, 1, 16'($urandom), 16'($urandom));
            mem_rdata = 16'($urandom);
            cycle();
            chk("burst_io_pat", obs_ig, bst_io_pat[i]);
            chk("burst_cpu_pat", obs_cg, bst_cpu_pat[i]);
        end
        idle(); cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    16'($urandom), 16'($urandom));
            set_io($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
            mem_rdata = 16'($urandom);
            cycle();
        end

        // Reset while a CPU read is being granted
        idle(); cycle();
        for (int i = 0; i < 2; i++) begin
            set_cpu(1, 0, 16'h0020, 16'h0); set_io(1, 0, 0, 16'h0030, 16'h0);
            cycle();
        end
        set_io(0, 0, 0, '0, '0);
        reset = 1'b1;
        cycle();
        chk("rst_rd_gnt", obs_cg, 1);
        reset = 1'b0;
        idle();
        cycle();
        chk("rst_rd_drop", obs_crv, 0);
        chk("rst_rd_state", obs_st, 2'd0);
        for (int i = 0; i < 6; i++) begin
            set_cpu(1, 0, 16'($urandom), 16'h0); set_io(1, 0, 0, 16'($urandom), 16'h0);
            mem_rdata = 16'($urandom);
            cycle();
            chk("rst_starve_clr", obs_ig, i == 4);
        end

`ifdef MEM_ARB_STATS_EN
        idle(); reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cpu(1, 0, 16'h0, 16'h0); set_io(1, 0, 0, 16'h0, 16'h0);
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            set_cpu(0, 0, 16'h0, 16'h0); set_io(1, 0, 0, 16'h0, 16'h0);
            cycle();
        end
        idle(); cycle();
        chk("stats_conflict", obs_conf, 16'd3);
        chk("stats_iogrant", obs_iog, 16'd2);
        for (int i = 0; i < 65532; i++) begin
            set_cpu(1, 0, 16'h0, 16'h0); set_io(1, 0, 0, 16'h0, 16'h0);
            cycle();
        end
        idle(); cycle();
        chk("stats_conf_max", obs_conf, 16'hFFFF);
        set_cpu(1, 0, 16'h0, 16'h0); set_io(1, 0, 0, 16'h0, 16'h0);
        cycle();
        idle(); cycle();
        chk("stats_conf_wrap", obs_conf, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
